// File: rtl/gc_pulse_serializer_if.sv
// gc_pulse_serializer_if
//   Byte-stream handshake between the TAS replay engine and the joybus
//   pulse serializer.
//   Signals:
//     tx_data   DATA_W  word to send, MSB first
//     tx_valid  1       tx_data/tx_last valid
//     tx_last   1       word is the last of a frame
//     tx_ready  1       serializer holding register empty
//   Modports: master (replay engine side), slave (serializer side).
interface gc_pulse_serializer_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_last;
  logic              tx_ready;

  modport master (output tx_data, output tx_valid, output tx_last, input tx_ready);
  modport slave  (input tx_data, input tx_valid, input tx_last, output tx_ready);
endinterface

// File: rtl/gc_pulse_serializer.sv
// gc_pulse_serializer
//   Serializes words onto the N64/GC joybus line. Each bit is a 4U cell
//   (U = CLK_PER_US cycles), MSB first: '0' = low 3U / high 1U,
//   '1' = low 1U / high 3U. A stop bit follows the last word of a frame.
//   Ports:
//     clk           system clock
//     rst_n         synchronous active-low reset
//     tx            slave side of gc_pulse_serializer_if (data/valid/last/ready)
//     pulse         line drive: 0 = pull low, 1 = release
//     transmitting  high from first falling edge to end of stop bit
//     frame_done    one-cycle strobe when the stop bit completes
//     underrun      one-cycle strobe, coincides with the start of the stop
//                   bit that terminates a frame whose next word never came
//   Build option: GC_PULSE_CTRL_STOP_EN selects a 2U (controller-style)
//   stop bit; otherwise the stop bit is 1U (console-style).
//
//   state    | meaning
//   ---------+--------------------------------------------------------
//   IDLE     | line released, waiting for a word in the holding register
//   BIT_LOW  | low part of the current bit cell (1U for '1', 3U for '0')
//   BIT_HIGH | high part of the current bit cell (remainder of 4U)
//   STOP_LOW | stop bit low time
//
//   Line outputs are registered from the state, so they trail the state by
//   one cycle; this keeps every segment's length equal to its state length.
module gc_pulse_serializer #(
  parameter int CLK_PER_US = 48,
  parameter int DATA_W     = 8,
  parameter int CNT_W      = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  gc_pulse_serializer_if.slave  tx,
  output logic                  pulse,
  output logic                  transmitting,
  output logic                  frame_done,
  output logic                  underrun
);

  localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

`ifdef GC_PULSE_CTRL_STOP_EN
  localparam logic [1:0] STOP_U = 2'd2;
`else
  localparam logic [1:0] STOP_U = 2'd1;
`endif

  typedef enum logic [1:0] {IDLE, BIT_LOW, BIT_HIGH, STOP_LOW} state_t;

  state_t            state;
  logic [CNT_W-1:0]  us_cnt;
  logic [1:0]        u_cnt;
  logic [BIT_W-1:0]  bit_idx;
  logic [DATA_W-1:0] shreg;
  logic              cur_last;
  logic [DATA_W-1:0] hold_data;
  logic              hold_last;
  logic              hold_full;
  logic              underrun_q;

  logic       cur_bit;
  logic       u_tick;
  logic [1:0] u_target;
  logic       seg_end;
  logic       word_end;
  logic       consume;
  logic       accept;
  logic       hold_full_nxt;

  assign cur_bit = shreg[DATA_W-1];
  assign u_tick  = (us_cnt == CNT_W'(CLK_PER_US - 1));

  // Index of the last U of the current segment.
  always_comb begin
    u_target = 2'd0;
    case (state)
      BIT_LOW:  u_target = cur_bit ? 2'd0 : 2'd2;
      BIT_HIGH: u_target = cur_bit ? 2'd2 : 2'd0;
      STOP_LOW: u_target = STOP_U - 2'd1;
      default:  u_target = 2'd0;
    endcase
  end

  assign seg_end  = (state != IDLE) && u_tick && (u_cnt == u_target);
  assign word_end = (state == BIT_HIGH) && seg_end && (bit_idx == BIT_W'(DATA_W - 1));
  assign consume  = hold_full && ((state == IDLE) || word_end);
  // A word offered while the hold is being drained is taken the next cycle,
  // once tx_ready has been re-asserted; a word never takes 1 cycle, so this
  // bubble cannot open a gap on the line.
  assign accept   = tx.tx_valid && !hold_full;
  assign hold_full_nxt = accept || (hold_full && !consume);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      us_cnt       <= '0;
      u_cnt        <= 2'd0;
      bit_idx      <= '0;
      shreg        <= '0;
      cur_last     <= 1'b0;
      hold_data    <= '0;
      hold_last    <= 1'b0;
      hold_full    <= 1'b0;
      tx.tx_ready  <= 1'b1;
      underrun_q   <= 1'b0;
      pulse        <= 1'b1;
      transmitting <= 1'b0;
      frame_done   <= 1'b0;
      underrun     <= 1'b0;
    end else begin
      if (accept) begin
        hold_data <= tx.tx_data;
        hold_last <= tx.tx_last;
      end
      hold_full   <= hold_full_nxt;
      tx.tx_ready <= !hold_full_nxt;

      if ((state == IDLE) || seg_end) begin
        us_cnt <= '0;
        u_cnt  <= 2'd0;
      end else if (u_tick) begin
        us_cnt <= '0;
        u_cnt  <= u_cnt + 2'd1;
      end else begin
        us_cnt <= us_cnt + 1'b1;
      end

      underrun_q <= 1'b0;
      case (state)
        IDLE: begin
          if (hold_full) begin
            shreg    <= hold_data;
            cur_last <= hold_last;
            bit_idx  <= '0;
            state    <= BIT_LOW;
          end
        end
        BIT_LOW: begin
          if (seg_end) state <= BIT_HIGH;
        end
        BIT_HIGH: begin
          if (seg_end) begin
            if (!word_end) begin
              shreg   <= shreg << 1;
              bit_idx <= bit_idx + 1'b1;
              state   <= BIT_LOW;
            end else if (hold_full) begin
              shreg    <= hold_data;
              cur_last <= hold_last;
              bit_idx  <= '0;
              state    <= BIT_LOW;
            end else begin
              underrun_q <= !cur_last;
              state      <= STOP_LOW;
            end
          end
        end
        STOP_LOW: begin
          if (seg_end) state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      pulse        <= !((state == BIT_LOW) || (state == STOP_LOW));
      transmitting <= (state != IDLE);
      // Previous cycle was the last of the stop bit: release, end and strobe together.
      frame_done   <= (state == IDLE) && transmitting;
      underrun     <= underrun_q;
    end
  end

endmodule

// File: tb/tb_gc_pulse_serializer.sv
// tb_gc_pulse_serializer
//   Bench for gc_pulse_serializer with CLK_PER_US=4, DATA_W=8. Expected line
//   waveforms are built from the bit-cell rules (low/high cycle counts per bit)
//   and compared with the captured pulse samples during transmitting.
module tb_gc_pulse_serializer;
  localparam int U  = 4;
  localparam int DW = 8;
`ifdef GC_PULSE_CTRL_STOP_EN
  localparam int STOP_CYC = 2 * U;
`else
  localparam int STOP_CYC = 1 * U;
`endif

  logic clk = 1'b0;
  logic rst_n;
  logic pulse, transmitting, frame_done, underrun;

  gc_pulse_serializer_if #(.DATA_W(DW)) tx_if ();

  gc_pulse_serializer #(.CLK_PER_US(U), .DATA_W(DW), .CNT_W(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .tx           (tx_if.slave),
    .pulse        (pulse),
    .transmitting (transmitting),
    .frame_done   (frame_done),
    .underrun     (underrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  // Monitor state, sampled on the falling edge.
  int cap[$];
  int seen_fall, fall_cyc, ur_cnt, ur_idx, fd_cnt, fd_pulse, fd_tx;

  always @(negedge clk) begin
    if (transmitting) begin
      if (underrun) ur_idx = cap.size();
      cap.push_back(int'(pulse));
      if (seen_fall == 0 && !pulse) begin
        seen_fall = 1;
        fall_cyc  = cyc;
      end
    end
    if (underrun) ur_cnt++;
    if (frame_done) begin
      fd_cnt++;
      fd_pulse = int'(pulse);
      fd_tx    = int'(transmitting);
    end
  end

  logic [7:0] fw [4];

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic mon_clear();
    cap.delete();
    seen_fall = 0; fall_cyc = 0; ur_cnt = 0; ur_idx = -1;
    fd_cnt = 0; fd_pulse = -1; fd_tx = -1;
  endtask

  task automatic send(input logic [7:0] d, input bit l, output int acc_cyc);
    int t;
    t = 0;
    tx_if.tx_data  = d;
    tx_if.tx_last  = l;
    tx_if.tx_valid = 1'b1;
    @(negedge clk);
    while (!tx_if.tx_ready && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 2000) check("send_timeout_ready", int'(tx_if.tx_ready), 1);
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    tx_if.tx_valid = 1'b0;
  endtask

  task automatic do_frame(input string tag, input int n, input bit end_last, input int max_gap);
    int acc, first_acc, t, diff, lo, b, m;
    int exp_q[$];
    mon_clear();
    first_acc = 0;
    for (int k = 0; k < n; k++) begin
      send(fw[k], (k == n - 1) ? end_last : 1'b0, acc);
      if (k == 0) first_acc = acc;
      repeat ($urandom_range(max_gap, 0)) @(posedge clk);
      #1;
    end
    t = 0;
    while (fd_cnt == 0 && t < 3000) begin
      @(posedge clk);
      t++;
    end
    repeat (3) @(posedge clk);
    #1;

    for (int k = 0; k < n; k++) begin
      for (int i = DW - 1; i >= 0; i--) begin
        b  = (fw[k] >> i) & 1;
        lo = b ? U : 3 * U;
        repeat (lo) exp_q.push_back(0);
        repeat (4 * U - lo) exp_q.push_back(1);
      end
    end
    repeat (STOP_CYC) exp_q.push_back(0);

    diff = -1;
    m = (cap.size() < exp_q.size()) ? cap.size() : exp_q.size();
    for (int i = 0; i < m; i++)
      if (diff < 0 && cap[i] !== exp_q[i]) diff = i;
    if (diff < 0 && cap.size() != exp_q.size()) diff = m;

    check($sformatf("%s_tx_len", tag), cap.size(), exp_q.size());
    check($sformatf("%s_wave_first_diff", tag), diff, -1);
    check($sformatf("%s_fall_latency", tag), fall_cyc - first_acc, 2);
    check($sformatf("%s_frame_done_cnt", tag), fd_cnt, 1);
    check($sformatf("%s_frame_done_pulse", tag), fd_pulse, 1);
    check($sformatf("%s_frame_done_tx", tag), fd_tx, 0);
    check($sformatf("%s_underrun_cnt", tag), ur_cnt, end_last ? 0 : 1);
    check($sformatf("%s_underrun_idx", tag), ur_idx, end_last ? -1 : n * DW * 4 * U);
    check($sformatf("%s_idle_pulse", tag), int'(pulse), 1);
    check($sformatf("%s_idle_ready", tag), int'(tx_if.tx_ready), 1);
  endtask

  initial begin
    int acc, pre, sz, t, n;
    bit el;
    rst_n = 1'b0;
    tx_if.tx_valid = 1'b0;
    tx_if.tx_data  = '0;
    tx_if.tx_last  = 1'b0;
    mon_clear();

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_pulse", int'(pulse), 1);
    check("rst_transmitting", int'(transmitting), 0);
    check("rst_ready", int'(tx_if.tx_ready), 1);
    check("rst_frame_done", int'(frame_done), 0);
    check("rst_underrun", int'(underrun), 0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // All-zero word, last
    fw[0] = 8'h00;
    do_frame("f00", 1, 1'b1, 0);

    // Two words back-to-back, single stop bit
    fw[0] = 8'h40; fw[1] = 8'h03;
    do_frame("f40_03", 2, 1'b1, 0);

    // Missing next word: underrun then stop bit
    fw[0] = 8'hFF;
    do_frame("fff_underrun", 1, 1'b0, 0);

    // Word after underrun starts a normal frame
    fw[0] = 8'h5A;
    do_frame("f5a_after_ur", 1, 1'b1, 0);

    // Reset during bit 3 of 0xAA, with a second word waiting in the hold
    mon_clear();
    send(8'hAA, 1'b1, acc);
    send(8'h55, 1'b1, acc);
    t = 0;
    while (cap.size() < 3 * 4 * U + 5 && t < 1000) begin
      @(posedge clk);
      t++;
    end
    #1;
    check("rstmid_reached_bit3", int'(cap.size() >= 3 * 4 * U + 5), 1);
    pre = int'(pulse);
    check("rstmid_low_before", pre, 0);
    check("rstmid_ready_before", int'(tx_if.tx_ready), 0);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("rstmid_pulse", int'(pulse), 1);
    check("rstmid_transmitting", int'(transmitting), 0);
    check("rstmid_ready", int'(tx_if.tx_ready), 1);
    sz = cap.size();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (400) @(posedge clk);
    #1;
    check("rstmid_no_frame_done", fd_cnt, 0);
    check("rstmid_no_more_tx", cap.size(), sz);
    check("rstmid_idle_pulse", int'(pulse), 1);

    // Randomized frames
    for (int f = 0; f < 8; f++) begin
      n  = $urandom_range(3, 1);
      el = ($urandom_range(3, 0) != 0);
      for (int k = 0; k < n; k++) fw[k] = 8'($urandom_range(255, 0));
      do_frame($sformatf("rnd%0d", f), n, el, 20);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
